// File: rtl/btn_pulse_conditioner.sv
// Five-lane button synchronizer, debouncer and press/auto-repeat pulse generator.
// Auto-repeat (RPT state, btn_rpt) is present only when BTN_AUTOREPEAT_EN is defined.
module btn_pulse_conditioner #(
  parameter int DB_CYCLES  = 1000000,
  parameter int RPT_CYCLES = 4000000,
  parameter int CNT_W      = 23
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic [4:0] btn_in,
  output logic [4:0] btn_db,
  output logic [4:0] btn_pulse,
  output logic [4:0] btn_rpt
);

`ifdef BTN_AUTOREPEAT_EN
  typedef enum logic [2:0] {
    IDLE, WQ, PULSE, HELD, RPT, REL
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, WQ, PULSE, HELD, REL
  } state_t;
`endif

  localparam longint CNT_LIM = longint'(1) << CNT_W;

  localparam logic [CNT_W-1:0] DB_LAST =
    CNT_W'(DB_CYCLES - 1);

  if (DB_CYCLES < 2 || RPT_CYCLES < 2 ||
      longint'(DB_CYCLES) >= CNT_LIM ||
      longint'(RPT_CYCLES) >= CNT_LIM)
  begin : g_param_err
    $error("btn_pulse_conditioner: bad DB/RPT/CNT_W");
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RPT_LAST =
    CNT_W'(RPT_CYCLES - 1);
`endif

  // Async assert, clock-synchronous release of the internal reset
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  for (genvar g = 0; g < 5; g++) begin : g_lane
    logic [1:0]       r_sync;
    logic             w_sync;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_db;
    logic             r_pulse;
`ifdef BTN_AUTOREPEAT_EN
    logic             r_rpt;
`endif

    always_ff @(posedge Clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
        r_sync <= 2'b00;
      end else begin
        r_sync <= {r_sync[0], btn_in[g]};
      end
    end

    assign w_sync = r_sync[1];

    always_ff @(posedge Clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_db    <= 1'b0;
        r_pulse <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        r_rpt   <= 1'b0;
`endif
      end else begin
        r_pulse <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        r_rpt   <= 1'b0;
`endif
        unique case (r_state)
          IDLE: begin
            r_cnt <= '0;
            if (w_sync) begin
              r_state <= WQ;
            end
          end
          WQ: begin
            if (!w_sync) begin
              r_state <= IDLE;
              r_cnt   <= '0;
            end else if (r_cnt == DB_LAST) begin
              r_state <= PULSE;
              r_cnt   <= '0;
              r_pulse <= 1'b1;
              r_db    <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          PULSE: begin
            r_state <= HELD;
            r_cnt   <= '0;
          end
          HELD: begin
            if (!w_sync) begin
              r_state <= REL;
              r_cnt   <= '0;
            end
`ifdef BTN_AUTOREPEAT_EN
            else if (r_cnt == RPT_LAST) begin
              r_state <= RPT;
              r_cnt   <= '0;
              r_rpt   <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
`endif
          end
`ifdef BTN_AUTOREPEAT_EN
          RPT: begin
            r_state <= HELD;
            r_cnt   <= '0;
          end
`endif
          REL: begin
            // A bounce back high resumes the hold without a new press
            if (w_sync) begin
              r_state <= HELD;
              r_cnt   <= '0;
            end else if (r_cnt == DB_LAST) begin
              r_state <= IDLE;
              r_cnt   <= '0;
              r_db    <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_db    <= 1'b0;
          end
        endcase
      end
    end

    assign btn_db[g]    = r_db;
    assign btn_pulse[g] = r_pulse;
`ifdef BTN_AUTOREPEAT_EN
    assign btn_rpt[g]   = r_rpt;
`else
    assign btn_rpt[g]   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_btn_pulse_conditioner.sv
// Bench for btn_pulse_conditioner: table-driven scoreboard plus reset sequences.
// Build with or without BTN_AUTOREPEAT_EN; repeat expectations follow the macro.
module tb_btn_pulse_conditioner;

  localparam int DB  = 4;
  localparam int RPT = 6;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit RPT_ON = 1'b1;
`else
  localparam bit RPT_ON = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] btn_in = 5'b0;
  logic [4:0] btn_db;
  logic [4:0] btn_pulse;
  logic [4:0] btn_rpt;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      name;
    logic [4:0] in;
    logic [4:0] db;
    logic [4:0] pu;
    logic [4:0] rp;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  btn_pulse_conditioner #(
    .DB_CYCLES(DB),
    .RPT_CYCLES(RPT),
    .CNT_W(8)
  ) dut (
    .Clk(Clk),
    .reset(reset),
    .btn_in(btn_in),
    .btn_db(btn_db),
    .btn_pulse(btn_pulse),
    .btn_rpt(btn_rpt)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm,
                     input logic [14:0] got,
                     input logic [14:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: db/pulse/rpt got %b_%b_%b required %b_%b_%b",
               nm, got[14:10], got[9:5], got[4:0],
               exp[14:10], exp[9:5], exp[4:0]);
    end
  endtask

  task automatic add(input string nm, input logic [4:0] in,
                     input logic [4:0] db, input logic [4:0] pu,
                     input logic [4:0] rp, input int n);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.name = nm;
      v.in = in;
      v.db = db;
      v.pu = pu;
      v.rp = rp;
      tbl.push_back(v);
    end
  endtask

  task automatic sb_pop();
    vec_t v;
    if (sb.size() != 0) begin
      v = sb.pop_front();
      chk(v.name, {btn_db, btn_pulse, btn_rpt}, {v.db, v.pu, v.rp});
    end
  endtask

  // Drive at negedge; the expectation is the output after the next posedge
  task automatic step(input vec_t v);
    @(negedge Clk);
    sb_pop();
    btn_in = v.in;
    sb.push_back(v);
  endtask

  // Count posedges from now until btn_pulse[0]; require full requalification
  task automatic measure(input string nm);
    int  k;
    bit  seen;
    seen = 1'b0;
    k = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge Clk);
      #1;
      if (btn_pulse[0] && !seen) begin
        seen = 1'b1;
        k = i;
        chk({nm, "_pulse_lanes"}, {10'b0, btn_pulse}, {10'b0, 5'b00001});
        break;
      end
    end
    n_tests++;
    if (!seen || k < DB + 3) begin
      n_fail++;
      $display("FAIL %s: pulse after %0d edges (seen=%0d) required >= %0d",
               nm, k, seen, DB + 3);
    end
    @(posedge Clk);
    #1;
    chk({nm, "_one_cycle"}, {btn_db, btn_pulse, 5'b0},
        {5'b00001, 5'b0, 5'b0});
  endtask

  initial begin
    logic [4:0] r;
    // Press lane 0, release before first repeat
    add("l0_qual", 5'b00001, 5'b0, 5'b0, 5'b0, 6);
    add("l0_pulse", 5'b00001, 5'b00001, 5'b00001, 5'b0, 1);
    add("l0_held", 5'b00001, 5'b00001, 5'b0, 5'b0, 3);
    add("l0_rel", 5'b0, 5'b00001, 5'b0, 5'b0, 6);
    add("l0_idle", 5'b0, 5'b0, 5'b0, 5'b0, 3);
    // Lane 2 glitch restarts qualification
    add("l2_burst", 5'b00100, 5'b0, 5'b0, 5'b0, 3);
    add("l2_gap", 5'b0, 5'b0, 5'b0, 5'b0, 1);
    add("l2_qual", 5'b00100, 5'b0, 5'b0, 5'b0, 6);
    add("l2_pulse", 5'b00100, 5'b00100, 5'b00100, 5'b0, 1);
    add("l2_held", 5'b00100, 5'b00100, 5'b0, 5'b0, 3);
    add("l2_rel", 5'b0, 5'b00100, 5'b0, 5'b0, 6);
    add("l2_idle", 5'b0, 5'b0, 5'b0, 5'b0, 3);
    // Lane 1 held for auto-repeat
    add("l1_qual", 5'b00010, 5'b0, 5'b0, 5'b0, 6);
    add("l1_pulse", 5'b00010, 5'b00010, 5'b00010, 5'b0, 1);
    for (int j = 7; j <= 36; j++) begin
      r = (RPT_ON && ((j - 6) % (RPT + 1) == 0)) ? 5'b00010 : 5'b0;
      add("l1_rpt", 5'b00010, 5'b00010, 5'b0, r, 1);
    end
    add("l1_rel", 5'b0, 5'b00010, 5'b0, 5'b0, 6);
    add("l1_idle", 5'b0, 5'b0, 5'b0, 5'b0, 3);
    // Lane 4 release bounce, then sustained release
    add("l4_qual", 5'b10000, 5'b0, 5'b0, 5'b0, 6);
    add("l4_pulse", 5'b10000, 5'b10000, 5'b10000, 5'b0, 1);
    add("l4_held", 5'b10000, 5'b10000, 5'b0, 5'b0, 1);
    add("l4_bounce", 5'b0, 5'b10000, 5'b0, 5'b0, 2);
    add("l4_back", 5'b10000, 5'b10000, 5'b0, 5'b0, 4);
    add("l4_rel", 5'b0, 5'b10000, 5'b0, 5'b0, 6);
    add("l4_idle", 5'b0, 5'b0, 5'b0, 5'b0, 3);
    // Lane 3: one sample short of qualifying, then exactly enough
    add("l3_short", 5'b01000, 5'b0, 5'b0, 5'b0, 4);
    add("l3_short_idle", 5'b0, 5'b0, 5'b0, 5'b0, 6);
    add("l3_exact", 5'b01000, 5'b0, 5'b0, 5'b0, 5);
    add("l3_exact_low", 5'b0, 5'b0, 5'b0, 5'b0, 1);
    add("l3_pulse", 5'b0, 5'b01000, 5'b01000, 5'b0, 1);
    add("l3_rel", 5'b0, 5'b01000, 5'b0, 5'b0, 5);
    add("l3_idle", 5'b0, 5'b0, 5'b0, 5'b0, 3);
    // All lanes together
    add("all_qual", 5'b11111, 5'b0, 5'b0, 5'b0, 6);
    add("all_pulse", 5'b11111, 5'b11111, 5'b11111, 5'b0, 1);
    add("all_held", 5'b11111, 5'b11111, 5'b0, 5'b0, 3);
    add("all_rel", 5'b0, 5'b11111, 5'b0, 5'b0, 6);
    add("all_idle", 5'b0, 5'b0, 5'b0, 5'b0, 3);

    #3;
    chk("reset_state", {btn_db, btn_pulse, btn_rpt}, 15'b0);
    repeat (2) @(negedge Clk);
    chk("reset_hold", {btn_db, btn_pulse, btn_rpt}, 15'b0);
    reset = 1'b1;
    repeat (4) @(negedge Clk);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i]);
    end
    @(negedge Clk);
    sb_pop();

    // Reset during qualification
    btn_in = 5'b00001;
    repeat (3) @(negedge Clk);
    #2 reset = 1'b0;
    #1 chk("rst_wq_async", {btn_db, btn_pulse, btn_rpt}, 15'b0);
    repeat (2) @(negedge Clk);
    chk("rst_wq_hold", {btn_db, btn_pulse, btn_rpt}, 15'b0);
    reset = 1'b1;
    measure("rst_wq_requal");

    // Reset while held (db high)
    @(posedge Clk);
    #2;
    chk("held_before_rst", {btn_db, btn_pulse, btn_rpt},
        {5'b00001, 5'b0, 5'b0});
    reset = 1'b0;
    #1 chk("rst_held_async", {btn_db, btn_pulse, btn_rpt}, 15'b0);
    repeat (2) @(negedge Clk);
    chk("rst_held_hold", {btn_db, btn_pulse, btn_rpt}, 15'b0);
    reset = 1'b1;
    measure("rst_held_requal");

    btn_in = 5'b0;
    repeat (12) @(negedge Clk);
    chk("final_idle", {btn_db, btn_pulse, btn_rpt}, 15'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_pulse_conditioner.md
BTN_PULSE_CONDITIONER -- requirements
Module: btn_pulse_conditioner

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 1000000: number of consecutive stable synchronized samples needed to accept a press or a release.
REQ-002 SHALL have parameter RPT_CYCLES, default 4000000: hold period between auto-repeat pulses.
REQ-003 SHALL have parameter CNT_W, default 23: counter width; DB_CYCLES and RPT_CYCLES SHALL be >=2 and <2^CNT_W.
REQ-004 SHALL have port Clk, input, 1: single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port btn_in, input, 5: raw buttons, bit order {BtnL, BtnU, BtnD, BtnR, BtnC} = [4:0].
REQ-007 SHALL have port btn_db, output, 5: debounced button level.
REQ-008 SHALL have port btn_pulse, output, 5: one-Clk pulse per accepted press; feeds the Start/Ack/Jump inputs of the game FSMs.
REQ-009 SHALL have port btn_rpt, output, 5: one-Clk auto-repeat pulse while a button is held.

Function
REQ-010 Each btn_in bit SHALL pass through its own two-flop synchronizer; all later logic SHALL use only the synchronized bit ("sync").
REQ-011 Each of the five bits SHALL have an independent FSM and a CNT_W-bit counter; no lane SHALL affect another.
REQ-012 FSM states SHALL be IDLE, WQ, PULSE, HELD, RPT, REL.
REQ-013 IDLE: counter=0; sync=1 -> WQ.
REQ-014 WQ: sync=0 -> IDLE with counter cleared; else the counter increments; when sync=1 and counter==DB_CYCLES-1 -> PULSE.
REQ-015 PULSE: lasts exactly one cycle, clears the counter, then -> HELD.
REQ-016 HELD: sync=0 -> REL with counter cleared; else the counter increments (only when auto-repeat is compiled in); when counter==RPT_CYCLES-1 -> RPT.
REQ-017 RPT: lasts exactly one cycle, clears the counter, then -> HELD.
REQ-018 REL: sync=1 -> HELD with counter cleared, and no new btn_pulse is issued; else the counter increments; when counter==DB_CYCLES-1 -> IDLE.
REQ-019 Outputs SHALL be registered state decodes:
- btn_pulse=1 only in PULSE.
- btn_rpt=1 only in RPT.
- btn_db=1 in PULSE, HELD, RPT and REL; 0 in IDLE and WQ.
REQ-020 Latency: with btn_in stable high, btn_pulse SHALL rise exactly DB_CYCLES+3 Clk edges after the first edge that samples btn_in high.
REQ-021 Glitch rejection: a low synchronized sample in WQ SHALL restart qualification; a high sample in REL SHALL restart release qualification.
REQ-022 The first btn_rpt SHALL occur RPT_CYCLES+1 cycles after btn_pulse; later pulses SHALL follow every RPT_CYCLES+1 cycles while the button is held.
REQ-023 The counter SHALL never wrap; it is always cleared before reaching 2^CNT_W-1.

Reset
REQ-024 reset=0 SHALL immediately, without waiting for a clock edge, force all synchronizer flops, counters and outputs to 0 and all FSMs to IDLE.
REQ-025 Reset asserted mid-press SHALL discard the press; after release of reset the button must re-qualify for the full DB_CYCLES.
REQ-026 Reset deassertion SHALL be synchronized internally to Clk.

Configuration
REQ-027 Macro BTN_AUTOREPEAT_EN:
- Defined: RPT state and btn_rpt behave as in REQ-016/017/022.
- Undefined: the RPT state and repeat counting are removed, btn_rpt is a constant 0, and HELD leaves only on sync=0.

Verification (DB_CYCLES=4, RPT_CYCLES=6, BTN_AUTOREPEAT_EN defined unless stated)
REQ-028 btn_in[0] rises and holds -> btn_pulse[0]=1 for exactly one cycle, 7 edges later; btn_db[0]=1 from then on; other lanes stay 0.
REQ-029 btn_in[2] high 3 cycles, low 1 cycle, then high -> no pulse from the first burst; one pulse 7 edges after the final rise.
REQ-030 Hold btn_in[1] for 30 cycles after its pulse -> btn_rpt[1] pulses at +7, +14, +21, +28 relative to btn_pulse; with the macro undefined, btn_rpt stays 0.
REQ-031 After a press, btn_in[4] drops for 2 cycles and returns high -> btn_db[4] stays 1 and no second btn_pulse; a sustained release drops btn_db[4] 7 edges after the falling edge.
REQ-032 reset=0 asserted in WQ and in HELD -> all outputs 0 asynchronously; after reset=1, a held button produces a fresh pulse only after the full qualification.
REQ-033 All five buttons pressed on the same edge -> five simultaneous one-cycle pulses on the same cycle.
